// File: rtl/cnt_step_pkg.sv
// Shared types and helpers for the count-step decoder.
// Holds the tracker state encoding, the default tally width and the expected-step function.
package cnt_step_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK  = 2'd1,
    FAULT = 2'd2
  } cnt_step_state_t;

  localparam int unsigned CNT_STEP_W_DEFAULT = 32'd16;

  // Modular difference that one legal enable leaves between consecutive samples.
  function automatic logic [31:0] exp_delta(input int unsigned w, input bit inc_dec);
    logic [31:0] down_step;
    down_step = (32'd1 << w) - 32'd1;
    if (inc_dec) begin
      return 32'd1;
    end else begin
      return down_step;
    end
  endfunction

endpackage

// File: rtl/cnt_step_sva.sv
// Property checker for cnt_step_decoder; bound in only when CNT_STEP_DECODER_SVA_EN is defined.
// Watches the tracker state and the registered outputs.
module cnt_step_sva
  import cnt_step_pkg::*;
#(
  parameter int unsigned STEP_W = CNT_STEP_W_DEFAULT
) (
  input logic            clk,
  input logic            rst_n,
  input cnt_step_state_t state_i,
  input logic            step_i,
  input logic            err_i,
  input logic            fault_i,
  input logic            lock_i,
  input logic [STEP_W-1:0] steps_i
);

  localparam logic [STEP_W-1:0] SAT = {STEP_W{1'b1}};

  a_step_err_excl: assert property (@(posedge clk) disable iff (!rst_n) !(step_i && err_i))
    else $warning("a_step_err_excl");
  c_step_err_excl: cover property (@(posedge clk) disable iff (!rst_n) !(step_i && err_i));

  a_fault_no_step: assert property (@(posedge clk) disable iff (!rst_n) (state_i == FAULT) |-> !step_i)
    else $warning("a_fault_no_step");
  c_fault_no_step: cover property (@(posedge clk) disable iff (!rst_n) (state_i == FAULT));

  // The tally moves on the same edge that raises step_o, so compare against the previous cycle.
  a_step_tally: assert property (@(posedge clk) disable iff (!rst_n)
      (step_i && ($past(steps_i) != SAT)) |-> (steps_i == ($past(steps_i) + {{(STEP_W-1){1'b0}}, 1'b1})))
    else $warning("a_step_tally");
  c_step_tally: cover property (@(posedge clk) disable iff (!rst_n) step_i && ($past(steps_i) != SAT));

  a_no_unknown: assert property (@(posedge clk) disable iff (!rst_n)
      !$isunknown({step_i, err_i, fault_i, lock_i, steps_i}))
    else $warning("a_no_unknown");
  c_no_unknown: cover property (@(posedge clk) disable iff (!rst_n)
      !$isunknown({step_i, err_i, fault_i, lock_i, steps_i}));

  a_reset_steps: assert property (@(posedge clk) disable iff (!rst_n) $rose(rst_n) |-> (steps_i == '0))
    else $warning("a_reset_steps");
  c_reset_steps: cover property (@(posedge clk) disable iff (!rst_n) $rose(rst_n));

endmodule

// File: rtl/cnt_step_decoder.sv
// Recovers enable pulses from an observed up/down counter value and flags illegal jumps.
// Define CNT_STEP_DECODER_SVA_EN to compile in the cnt_step_sva property checker.
module cnt_step_decoder
  import cnt_step_pkg::*;
#(
  parameter int unsigned W       = 32'd8,
  parameter bit          INC_DEC = 1'b1,
  parameter int unsigned STEP_W  = CNT_STEP_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [W-1:0]      cnt_i,
  input  logic              clr_i,
  output logic              step_o,
  output logic              err_o,
  output logic              fault_o,
  output logic              lock_o,
  output logic [STEP_W-1:0] steps_o
);

  localparam logic [W-1:0]      EXP_DELTA = W'(exp_delta(W, INC_DEC));
  localparam logic [STEP_W-1:0] SAT       = {STEP_W{1'b1}};

  cnt_step_state_t   state_q, state_d;
  logic [W-1:0]      ref_q, ref_d;
  logic              step_q, step_d;
  logic              err_q, err_d;
  logic              fault_q, fault_d;
  logic              lock_q, lock_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [W-1:0]      delta_s;

  assign delta_s = cnt_i - ref_q;

  // Next-state and registered-output computation; clr_i overrides any same-cycle sample.
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    step_d  = 1'b0;
    err_d   = 1'b0;
    fault_d = fault_q;
    lock_d  = lock_q;
    steps_d = steps_q;
    if (clr_i) begin
      state_d = IDLE;
      ref_d   = {W{1'b0}};
      fault_d = 1'b0;
      lock_d  = 1'b0;
      steps_d = {STEP_W{1'b0}};
    end else if (valid_i) begin
      case (state_q)
        IDLE: begin
          ref_d   = cnt_i;
          state_d = LOCK;
          lock_d  = 1'b1;
        end
        LOCK: begin
          if (delta_s == EXP_DELTA) begin
            step_d = 1'b1;
            ref_d  = cnt_i;
            if (steps_q != SAT) begin
              steps_d = steps_q + {{(STEP_W-1){1'b0}}, 1'b1};
            end else begin
              steps_d = steps_q;
            end
          end else if (delta_s == {W{1'b0}}) begin
            state_d = LOCK;
          end else begin
            err_d   = 1'b1;
            fault_d = 1'b1;
            lock_d  = 1'b0;
            state_d = FAULT;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = IDLE;
          lock_d  = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ref_q   <= {W{1'b0}};
      step_q  <= 1'b0;
      err_q   <= 1'b0;
      fault_q <= 1'b0;
      lock_q  <= 1'b0;
      steps_q <= {STEP_W{1'b0}};
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      step_q  <= step_d;
      err_q   <= err_d;
      fault_q <= fault_d;
      lock_q  <= lock_d;
      steps_q <= steps_d;
    end
  end

  assign step_o  = step_q;
  assign err_o   = err_q;
  assign fault_o = fault_q;
  assign lock_o  = lock_q;
  assign steps_o = steps_q;

`ifdef CNT_STEP_DECODER_SVA_EN
  cnt_step_sva #(.STEP_W(STEP_W)) u_sva (
    .clk     (clk),
    .rst_n   (rst_n),
    .state_i (state_q),
    .step_i  (step_q),
    .err_i   (err_q),
    .fault_i (fault_q),
    .lock_i  (lock_q),
    .steps_i (steps_q)
  );
`else
  // Property checker not compiled in.
`endif

endmodule

// File: tb/tb_cnt_step_decoder.sv
// Directed self-checking bench for cnt_step_decoder: up, down and narrow-tally instances share stimulus.
// Observed bundles are {step, err, fault, lock, steps}.
module tb_cnt_step_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] cnt = 8'd0;
  logic       clr = 1'b0;

  logic        up_step, up_err, up_fault, up_lock;
  logic [15:0] up_steps;
  logic        dn_step, dn_err, dn_fault, dn_lock;
  logic [15:0] dn_steps;
  logic        sat_step, sat_err, sat_fault, sat_lock;
  logic [3:0]  sat_steps;

  logic [19:0] obs_up, obs_dn, exp20;
  logic [7:0]  obs_sat, exp8;

  int checks = 0;
  int fails  = 0;

  assign obs_up  = {up_step, up_err, up_fault, up_lock, up_steps};
  assign obs_dn  = {dn_step, dn_err, dn_fault, dn_lock, dn_steps};
  assign obs_sat = {sat_step, sat_err, sat_fault, sat_lock, sat_steps};

  always #5 clk = ~clk;

  cnt_step_decoder #(.W(8), .INC_DEC(1'b1), .STEP_W(16)) u_up (
    .clk(clk), .rst_n(rst_n), .valid_i(valid), .cnt_i(cnt), .clr_i(clr),
    .step_o(up_step), .err_o(up_err), .fault_o(up_fault), .lock_o(up_lock), .steps_o(up_steps)
  );

  cnt_step_decoder #(.W(8), .INC_DEC(1'b0), .STEP_W(16)) u_dn (
    .clk(clk), .rst_n(rst_n), .valid_i(valid), .cnt_i(cnt), .clr_i(clr),
    .step_o(dn_step), .err_o(dn_err), .fault_o(dn_fault), .lock_o(dn_lock), .steps_o(dn_steps)
  );

  cnt_step_decoder #(.W(8), .INC_DEC(1'b1), .STEP_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .valid_i(valid), .cnt_i(cnt), .clr_i(clr),
    .step_o(sat_step), .err_o(sat_err), .fault_o(sat_fault), .lock_o(sat_lock), .steps_o(sat_steps)
  );

  // One clock with the given inputs; returns 1 ns after the edge so the response is visible.
  task automatic cyc(input logic v, input logic [7:0] c, input logic cl);
    valid = v;
    cnt   = c;
    clr   = cl;
    @(posedge clk);
    #1;
    valid = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    exp20 = 20'h00000;
    checks++;
    if (obs_up !== exp20) begin fails++; $display("FAIL reset_up got=%h exp=%h", obs_up, exp20); end
    exp8 = 8'h00;
    checks++;
    if (obs_sat !== exp8) begin fails++; $display("FAIL reset_sat got=%h exp=%h", obs_sat, exp8); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_up_basic;
    cyc(1'b1, 8'd5, 1'b0);
    exp20 = {4'b0001, 16'd0};
    checks++;
    if (obs_up !== exp20) begin fails++; $display("FAIL up_first got=%h exp=%h", obs_up, exp20); end
    cyc(1'b1, 8'd6, 1'b0);
    exp20 = {4'b1001, 16'd1};
    checks++;
    if (obs_up !== exp20) begin fails++; $display("FAIL up_step6 got=%h exp=%h", obs_up, exp20); end
    cyc(1'b1, 8'd7, 1'b0);
    exp20 = {4'b1001, 16'd2};
    checks++;
    if (obs_up !== exp20) begin fails++; $display("FAIL up_step7 got=%h exp=%h", obs_up, exp20); end
    cyc(1'b0, 8'd99, 1'b0);
    exp20 = {4'b0001, 16'd2};
    checks++;
    if (obs_up !== exp20) begin fails++; $display("FAIL up_novalid got=%h exp=%h", obs_up, exp20); end
    cyc(1'b1, 8'd8, 1'b0);
    exp20 = {4'b1001, 16'd3};
    checks++;
    if (obs_up !== exp20) begin fails++; $display("FAIL up_after_idle got=%h exp=%h", obs_up, exp20); end
  endtask

  task automatic test_up_wrap;
    cyc(1'b0, 8'd0, 1'b1);
    cyc(1'b1, 8'hFE, 1'b0);
    exp20 = {4'b0001, 16'd0};
    checks++;
    if (obs_up !== exp20) begin fails++; $display("FAIL wrap_first got=%h exp=%h", obs_up, exp20); end
    cyc(1'b1, 8'hFF, 1'b0);
    exp20 = {4'b1001, 16'd1};
    checks++;
    if (obs_up !== exp20) begin fails++; $display("FAIL wrap_ff got=%h exp=%h", obs_up, exp20); end
    cyc(1'b1, 8'h00, 1'b0);
    exp20 = {4'b1001, 16'd2};
    checks++;
    if (obs_up !== exp20) begin fails++; $display("FAIL wrap_00 got=%h exp=%h", obs_up, exp20); end
    cyc(1'b1, 8'h00, 1'b0);
    exp20 = {4'b0001, 16'd2};
    checks++;
    if (obs_up !== exp20) begin fails++; $display("FAIL wrap_repeat got=%h exp=%h", obs_up, exp20); end
  endtask

  task automatic test_down;
    cyc(1'b0, 8'd0, 1'b1);
    cyc(1'b1, 8'h01, 1'b0);
    exp20 = {4'b0001, 16'd0};
    checks++;
    if (obs_dn !== exp20) begin fails++; $display("FAIL dn_first got=%h exp=%h", obs_dn, exp20); end
    cyc(1'b1, 8'h00, 1'b0);
    exp20 = {4'b1001, 16'd1};
    checks++;
    if (obs_dn !== exp20) begin fails++; $display("FAIL dn_step00 got=%h exp=%h", obs_dn, exp20); end
    cyc(1'b1, 8'hFF, 1'b0);
    exp20 = {4'b1001, 16'd2};
    checks++;
    if (obs_dn !== exp20) begin fails++; $display("FAIL dn_wrapff got=%h exp=%h", obs_dn, exp20); end
  endtask

  task automatic test_fault;
    cyc(1'b0, 8'd0, 1'b1);
    cyc(1'b1, 8'd10, 1'b0);
    cyc(1'b1, 8'd12, 1'b0);
    exp20 = {4'b0110, 16'd0};
    checks++;
    if (obs_up !== exp20) begin fails++; $display("FAIL fault_jump got=%h exp=%h", obs_up, exp20); end
    cyc(1'b1, 8'd13, 1'b0);
    exp20 = {4'b0010, 16'd0};
    checks++;
    if (obs_up !== exp20) begin fails++; $display("FAIL fault_frozen got=%h exp=%h", obs_up, exp20); end
    cyc(1'b0, 8'd0, 1'b1);
    exp20 = {4'b0000, 16'd0};
    checks++;
    if (obs_up !== exp20) begin fails++; $display("FAIL fault_clr got=%h exp=%h", obs_up, exp20); end
    cyc(1'b1, 8'd20, 1'b0);
    exp20 = {4'b0001, 16'd0};
    checks++;
    if (obs_up !== exp20) begin fails++; $display("FAIL fault_relock got=%h exp=%h", obs_up, exp20); end
  endtask

  task automatic test_clr_priority;
    cyc(1'b1, 8'd21, 1'b0);
    cyc(1'b1, 8'd22, 1'b1);
    exp20 = {4'b0000, 16'd0};
    checks++;
    if (obs_up !== exp20) begin fails++; $display("FAIL clr_wins got=%h exp=%h", obs_up, exp20); end
    cyc(1'b1, 8'd23, 1'b0);
    exp20 = {4'b0001, 16'd0};
    checks++;
    if (obs_up !== exp20) begin fails++; $display("FAIL clr_sample_dropped got=%h exp=%h", obs_up, exp20); end
  endtask

  task automatic test_saturation;
    logic [3:0] exp_cnt;
    cyc(1'b0, 8'd0, 1'b1);
    cyc(1'b1, 8'd0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      exp_cnt = (i < 15) ? 4'(i) : 4'd15;
      exp8 = {4'b1001, exp_cnt};
      checks++;
      if (obs_sat !== exp8) begin fails++; $display("FAIL sat_step%0d got=%h exp=%h", i, obs_sat, exp8); end
    end
  endtask

  task automatic test_async_reset;
    cyc(1'b0, 8'd0, 1'b1);
    cyc(1'b1, 8'd0, 1'b0);
    cyc(1'b1, 8'd1, 1'b0);
    cyc(1'b1, 8'd2, 1'b0);
    cyc(1'b1, 8'd3, 1'b0);
    exp20 = {4'b1001, 16'd3};
    checks++;
    if (obs_up !== exp20) begin fails++; $display("FAIL arst_pre got=%h exp=%h", obs_up, exp20); end
    #1;
    rst_n = 1'b0;
    #1;
    exp20 = 20'h00000;
    checks++;
    if (obs_up !== exp20) begin fails++; $display("FAIL arst_immediate got=%h exp=%h", obs_up, exp20); end
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 8'd3, 1'b0);
    exp20 = {4'b0001, 16'd0};
    checks++;
    if (obs_up !== exp20) begin fails++; $display("FAIL arst_first_sample got=%h exp=%h", obs_up, exp20); end
    cyc(1'b1, 8'd4, 1'b0);
    exp20 = {4'b1001, 16'd1};
    checks++;
    if (obs_up !== exp20) begin fails++; $display("FAIL arst_next_step got=%h exp=%h", obs_up, exp20); end
  endtask

  initial begin
    test_reset();
    test_up_basic();
    test_up_wrap();
    test_down();
    test_fault();
    test_clr_priority();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cnt_step_decoder.md
# cnt_step_decoder

Recovers the enable pulses that drove an 8-bit free-running up/down counter by watching its count value, the receive end of the counter-with-enable path. Each qualified sample is compared with the previous one. A legal single step produces a one-cycle `step_o` pulse and a step tally; any other jump flags a fault. Sits beside counter instances in checker/monitor subsystems and in downstream logic that needs event pulses from a remote count.

## Interface
- `W`, 8, count width being decoded.
- `INC_DEC`, 1, expected direction: 1 = up (+1), 0 = down (−1 mod 2^W).
- `STEP_W`, 16, width of the step tally.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `valid_i`  in  1  `cnt_i` is a sample this cycle.
- `cnt_i`  in  W  observed counter value.
- `clr_i`  in  1  synchronous clear: tally, fault and lock.
- `step_o`  out  1  one-cycle pulse per recovered enable.
- `err_o`  out  1  one-cycle pulse on illegal jump.
- `fault_o`  out  1  sticky fault flag.
- `lock_o`  out  1  reference sample held, tracking active.
- `steps_o`  out  STEP_W  saturating count of recovered steps.

## Operation
- State machine with three states: `IDLE` (no reference), `LOCK` (tracking), `FAULT` (frozen).
- `IDLE`:
  - `valid_i` → capture `cnt_i` into `ref`, go to `LOCK`.
  - No step or error is produced.
- `LOCK`, on `valid_i`, `delta = cnt_i - ref` mod 2^W:
  - `delta == 0` → hold; no pulse.
  - `delta == 1` (`INC_DEC=1`) or `delta == 2^W-1` (`INC_DEC=0`) → `step_o` pulse, `steps_o` +1, `ref <= cnt_i`.
  - Any other `delta` → `err_o` pulse, `fault_o` set, go to `FAULT`; `ref` unchanged.
- `FAULT`:
  - Samples are ignored; `step_o` stays 0.
  - Only `clr_i` or reset leaves this state.
- `clr_i`, in any state:
  - Next state `IDLE`.
  - `steps_o`, `fault_o`, `lock_o` cleared; `ref` invalidated.
  - `clr_i` wins over a same-cycle `valid_i`: that sample is discarded.
- Wrap-around is a legal step: 0xFF→0x00 (up) and 0x00→0xFF (down).
- `steps_o` saturates at all-ones. The step that would overflow still pulses `step_o`.
- `step_o` and `err_o` are never high together.
- `valid_i=0` means no state change.

## Timing
- All outputs are registered. The response to a sample at edge N appears after edge N (visible in cycle N+1).
- Pulse width: `step_o` and `err_o` are exactly one cycle per qualifying sample. Back-to-back legal samples give back-to-back pulses.
- `lock_o` rises in the cycle after the first accepted sample in `IDLE`. It falls on entry to `FAULT` or after `clr_i`.
- Reset values: `step_o=0`, `err_o=0`, `fault_o=0`, `lock_o=0`, `steps_o=0`, state `IDLE`, `ref=0`.
- Reset is asynchronous. Asserting `rst_n` mid-operation immediately forces the reset values.
- The first sample after reset release only establishes the reference.
- Throughput: one sample per cycle, no backpressure.

## Configuration
- Macro `CNT_STEP_DECODER_SVA_EN`.
- Defined: the block compiles in concurrent assertions plus a cover for each. All use `disable iff(!rst_n)`. They check:
  - `!(step_o && err_o)`;
  - `FAULT |-> !step_o`;
  - `step_o |=> steps_o == $past(steps_o)+1` unless saturated;
  - `!$isunknown` on all outputs;
  - reset leaves `steps_o==0` on the next edge.
  
  A failure issues `$warning` naming the assertion.
- Undefined: no assertion or cover logic is present; functional behaviour is identical.

## Structure
- Package `cnt_step_pkg` holds:
  - typedef enum `cnt_step_state_t {IDLE, LOCK, FAULT}`;
  - the default `STEP_W` constant;
  - the function `exp_delta(W, INC_DEC)`.
- One sub-module, `cnt_step_sva`, holds the properties. It is instantiated only under `CNT_STEP_DECODER_SVA_EN` and connected to the internal state and outputs.

## Test plan
- Reset, then samples 5, 6, 7 with `INC_DEC=1` → first sample only raises `lock_o`; then two `step_o` pulses; `steps_o=2`.
- `INC_DEC=1`, samples 0xFE, 0xFF, 0x00, 0x00 → two pulses (including the wrap); the repeated 0x00 gives no pulse; `steps_o=2`.
- `INC_DEC=0`, samples 0x01, 0x00, 0xFF → two pulses, `fault_o=0`.
- `INC_DEC=1`, samples 10, 12 → `err_o` single pulse, `fault_o=1`, `lock_o=0`. A following 13 gives no `step_o`. Then `clr_i` → `fault_o=0`, `steps_o=0`, state `IDLE`.
- `STEP_W=4`, 20 consecutive legal steps → `steps_o` sticks at 15 while `step_o` keeps pulsing.
- `rst_n` asserted while in `LOCK` with `steps_o=3` → outputs zero immediately. After release, sample 3 → only `lock_o` rises.
